// File: rtl/rx_coef_loader_pkg.sv
// Shared definitions for the RX band-pass coefficient path: FSM encodings,
// default RAM geometry (also used by the band-pass filter and its RAM) and
// the checksum width.
package rx_coef_loader_pkg;

    localparam int NUM_COEF_DEF = 512;
    localparam int ADDR_W_DEF   = 9;
    localparam int TIMEOUT_DEF  = 4096;
    localparam int CSUM_W       = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CHECK = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

endpackage

// File: rtl/rx_idle_timer.sv
// Idle watchdog for RX loaders: a down-counter reloaded on every arm pulse.
// expired is asserted in the TIMEOUT-th consecutive running cycle without arm.
// Only instantiated when RX_COEF_TIMEOUT_EN is defined.
module rx_idle_timer #(
    parameter int TIMEOUT = 4096
) (
    input  logic clk,
    input  logic rrx_rst,
    input  logic arm,
    input  logic run,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;

    // Terminal count reached while running and not being re-armed.
    assign expired = run && !arm && (cnt_q == '0);

    // Reload on arm, count down while running, hold at zero.
    always_ff @(posedge clk) begin
        if (!rrx_rst) begin
            cnt_q <= '0;
        end else if (arm) begin
            cnt_q <= RELOAD;
        end else if (run && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/rx_coef_loader.sv
// Writer side of the RX band-pass coefficient RAM. Streams NUM_COEF words
// into RAM port A from address 0, then compares a trailing 16-bit checksum
// (sum of coefficients mod 2^16). Optional idle abort: RX_COEF_TIMEOUT_EN.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for start, s_ready low
//   ST_LOAD  | accepting coefficients, one RAM write per handshake
//   ST_CHECK | accepting the checksum word, no RAM write
//   ST_FIN   | one-cycle done pulse, back to idle
module rx_coef_loader
    import rx_coef_loader_pkg::*;
#(
    parameter int NUM_COEF = NUM_COEF_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rrx_rst,
    input  logic              start,
    input  logic              s_valid,
    input  logic [15:0]       s_data,
    output logic              s_ready,
    output logic              ena,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [15:0]       dia,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_cnt
);

    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(NUM_COEF - 1);

    state_t              state_q, state_d;
    logic [CSUM_W-1:0]   acc_q;
    logic                hs;
    logic                tmo;
    logic                start_ok;
    logic                wr_d;
    logic                ready_d;
    logic                busy_d;
    logic                done_d;

    assign hs       = s_valid && s_ready;
    assign start_ok = (state_q == ST_IDLE) && start;

`ifdef RX_COEF_TIMEOUT_EN
    rx_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clk     (clk),
        .rrx_rst (rrx_rst),
        .arm     (start_ok || hs),
        .run     ((state_q == ST_LOAD) || (state_q == ST_CHECK)),
        .expired (tmo)
    );
`else
    assign tmo = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rrx_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a handshake always wins over a coincident timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_LOAD;
            ST_LOAD: begin
                if (hs && (word_cnt == LAST_CNT)) state_d = ST_CHECK;
                else if (tmo)                     state_d = ST_FIN;
            end
            ST_CHECK: if (hs || tmo) state_d = ST_FIN;
            ST_FIN:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output decode, taken from the next state so the flops below line up with it.
    always_comb begin
        ready_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        wr_d    = (state_q == ST_LOAD) && hs;
        case (state_d)
            ST_LOAD, ST_CHECK: begin
                ready_d = 1'b1;
                busy_d  = 1'b1;
            end
            ST_FIN:  done_d = 1'b1;
            default: ;
        endcase
    end

    // Registered outputs, RAM write port, counters and checksum accumulator.
    always_ff @(posedge clk) begin
        if (!rrx_rst) begin
            s_ready  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ena      <= 1'b0;
            wea      <= 1'b0;
            addra    <= '0;
            dia      <= '0;
            err      <= 1'b0;
            word_cnt <= '0;
            acc_q    <= '0;
        end else begin
            s_ready <= ready_d;
            busy    <= busy_d;
            done    <= done_d;
            ena     <= wr_d;
            wea     <= wr_d;
            if (start_ok) begin
                word_cnt <= '0;
                acc_q    <= '0;
                err      <= 1'b0;
            end
            if (wr_d) begin
                addra    <= word_cnt[ADDR_W-1:0];
                dia      <= s_data;
                word_cnt <= word_cnt + 1'b1;
                acc_q    <= acc_q + s_data;
            end
            if ((state_q == ST_CHECK) && hs) begin
                err <= (s_data != acc_q);
            end else if (tmo) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rx_coef_loader.sv
// Scoreboard bench for rx_coef_loader: stimulus pushes expected RAM writes
// and expected done results; a negedge monitor pops and compares.
module tb_rx_coef_loader;

    localparam int N  = 512;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rrx_rst = 1'b0;
    logic          start = 1'b0;
    logic          s_valid = 1'b0;
    logic [15:0]   s_data = '0;
    logic          s_ready, ena, wea, busy, done, err;
    logic [AW-1:0] addra;
    logic [15:0]   dia;
    logic [AW:0]   word_cnt;

    always #5 clk = ~clk;

    rx_coef_loader #(
        .NUM_COEF (N),
        .ADDR_W   (AW),
        .TIMEOUT  (16)
    ) dut (
        .clk      (clk),
        .rrx_rst  (rrx_rst),
        .start    (start),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_ready  (s_ready),
        .ena      (ena),
        .wea      (wea),
        .addra    (addra),
        .dia      (dia),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .word_cnt (word_cnt)
    );

    typedef struct { logic [AW-1:0] addr; logic [15:0] data; } wr_t;
    typedef struct { logic e; logic [AW:0] cnt; } done_t;

    wr_t   exp_wr[$];
    done_t exp_done[$];
    wr_t   w_m;
    done_t d_m;
    int    checks = 0;
    int    passes = 0;
    int    done_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    endtask

    // Monitor: every RAM write and every done pulse must match the queue head.
    always @(negedge clk) begin
        if (wea !== ena) check("wea_follows_ena", {31'd0, wea}, {31'd0, ena});
        if (ena) begin
            check("write_expected", {31'd0, exp_wr.size() != 0}, 32'd1);
            if (exp_wr.size() != 0) begin
                w_m = exp_wr.pop_front();
                check("write_addr", {23'd0, addra}, {23'd0, w_m.addr});
                check("write_data", {16'd0, dia}, {16'd0, w_m.data});
            end
        end
        if (done) begin
            done_seen++;
            check("done_expected", {31'd0, exp_done.size() != 0}, 32'd1);
            if (exp_done.size() != 0) begin
                d_m = exp_done.pop_front();
                check("done_err", {31'd0, err}, {31'd0, d_m.e});
                check("done_word_cnt", {22'd0, word_cnt}, {22'd0, d_m.cnt});
                check("done_busy_low", {31'd0, busy}, 32'd0);
            end
        end
    end

    task automatic send(input logic [15:0] d, input int gap, input bit with_start);
        int n;
        repeat (gap) begin
            @(negedge clk);
            s_valid = 1'b0;
            start   = 1'b0;
        end
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        start   = with_start;
        n = 0;
        while (!s_ready && n < 50) begin
            @(negedge clk);
            start = 1'b0;
            n++;
        end
        if (n == 50) check("s_ready_wait", {31'd0, s_ready}, 32'd1);
        @(posedge clk);
    endtask

    task automatic go_idle();
        @(negedge clk);
        s_valid = 1'b0;
        start   = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", {31'd0, busy}, 32'd1);
        check("start_ready", {31'd0, s_ready}, 32'd1);
        check("start_err_clear", {31'd0, err}, 32'd0);
        check("start_word_cnt", {22'd0, word_cnt}, 32'd0);
    endtask

    task automatic wait_done(input int d0, input int bound);
        int n;
        n = 0;
        while (done_seen == d0 && n < bound) begin
            @(posedge clk);
            n++;
        end
        check("done_seen", {31'd0, done_seen > d0}, 32'd1);
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_ready", {31'd0, s_ready}, 32'd0);
    endtask

    // mode 0: words 1..N back-to-back; 1: 0xFFFF with valid toggling;
    // 2: random data with random gaps. start_at re-pulses start during that word.
    task automatic run_load(input int mode, input bit bad, input int start_at);
        logic [15:0] words[N];
        int          sum;
        int          d0;
        int          gap;
        sum = 0;
        for (int i = 0; i < N; i++) begin
            case (mode)
                0:       words[i] = 16'(i + 1);
                1:       words[i] = 16'hFFFF;
                default: words[i] = 16'($urandom());
            endcase
            sum += int'(words[i]);
        end
        d0 = done_seen;
        pulse_start();
        for (int i = 0; i < N; i++) begin
            gap = (mode == 1) ? 1 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
            exp_wr.push_back('{addr: AW'(i), data: words[i]});
            send(words[i], gap, i == start_at);
        end
        exp_done.push_back('{e: bad, cnt: (AW + 1)'(N)});
        send(16'(sum + (bad ? 1 : 0)), (mode == 1) ? 1 : 0, 1'b0);
        go_idle();
        wait_done(d0, 20);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_s_ready", {31'd0, s_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_ena", {31'd0, ena}, 32'd0);
        check("rst_addra", {23'd0, addra}, 32'd0);
        check("rst_dia", {16'd0, dia}, 32'd0);
        check("rst_word_cnt", {22'd0, word_cnt}, 32'd0);
        rrx_rst = 1'b1;

        // s_valid in idle must not be consumed or written.
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = 16'h1234;
        repeat (3) @(negedge clk);
        check("idle_no_ready", {31'd0, s_ready}, 32'd0);
        s_valid = 1'b0;

        run_load(0, 1'b0, -1);
        run_load(0, 1'b1, -1);
        check("err_sticky", {31'd0, err}, 32'd1);
        run_load(1, 1'b0, -1);

        // Reset after 100 words: everything returns to reset values, no done.
        pulse_start();
        for (int i = 0; i < 100; i++) begin
            exp_wr.push_back('{addr: AW'(i), data: 16'(i * 7 + 3)});
            send(16'(i * 7 + 3), 0, 1'b0);
        end
        go_idle();
        rrx_rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_addra", {23'd0, addra}, 32'd0);
        check("midrst_word_cnt", {22'd0, word_cnt}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_ready", {31'd0, s_ready}, 32'd0);
        rrx_rst = 1'b1;
        run_load(2, 1'b0, -1);

        run_load(0, 1'b0, 50);
        run_load(2, 1'($urandom_range(0, 1)), -1);
        run_load(2, 1'b1, N - 1);

`ifdef RX_COEF_TIMEOUT_EN
        begin
            int d0;
            d0 = done_seen;
            pulse_start();
            for (int i = 0; i < 10; i++) begin
                exp_wr.push_back('{addr: AW'(i), data: 16'(i + 100)});
                send(16'(i + 100), 0, 1'b0);
            end
            exp_done.push_back('{e: 1'b1, cnt: (AW + 1)'(10)});
            go_idle();
            repeat (14) @(negedge clk);
            check("tmo_not_early", {31'd0, busy}, 32'd1);
            wait_done(d0, 40);
        end
`endif

        repeat (5) @(negedge clk);
        check("writes_drained", exp_wr.size(), 32'd0);
        check("dones_drained", exp_done.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
